// File: rtl/muldiv_unit_if.sv
// Start/busy/done handshake and operand bus between the core and the RV32M multiply/divide unit.
interface muldiv_unit_if #(
    parameter int unsigned XLEN = 32
);
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            kill;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    // Core side: issues requests and aborts, observes status and result.
    modport master (
        output start, funct3, op_a, op_b, kill,
        input  busy, done, result
    );

    // Unit side.
    modport slave (
        input  start, funct3, op_a, op_b, kill,
        output busy, done, result
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative radix-2 RV32M multiply/divide unit. Operands are reduced to unsigned magnitudes on
// accept, one shift-add or restoring-divide step runs per clock, and all sign correction happens
// in a single fix-up cycle before the registered result is published with a one-cycle done pulse.
module muldiv_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic         clk,
    input  logic         rst,
    muldiv_unit_if.slave mdu
);
    localparam int unsigned CntW = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MinVal = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

    state_e            state_q, state_d;
    logic [2:0]        funct3_q, funct3_d;
    logic              neg_a_q, neg_a_d;
    logic              neg_b_q, neg_b_d;
    logic [XLEN-1:0]   b_mag_q, b_mag_d;
    // Multiply: {product_hi, multiplier/product_lo}. Divide: {remainder, dividend/quotient}.
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              special_q, special_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              done_q, done_d;

    logic              signed_a, signed_b, div0, ovf;
    logic [XLEN-1:0]   a_mag;
    logic [XLEN:0]     sum;
    logic [XLEN:0]     trial;
    logic [XLEN-1:0]   diff;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem;

    assign mdu.busy   = (state_q != StIdle);
    assign mdu.done   = done_q;
    assign mdu.result = result_q;

    // Next-state, datapath step and fix-up selection.
    always_comb begin
        state_d   = state_q;
        funct3_d  = funct3_q;
        neg_a_d   = neg_a_q;
        neg_b_d   = neg_b_q;
        b_mag_d   = b_mag_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        special_d = special_q;
        result_d  = result_q;
        done_d    = 1'b0;
        signed_a  = 1'b0;
        signed_b  = 1'b0;
        div0      = 1'b0;
        ovf       = 1'b0;
        a_mag     = '0;
        sum       = '0;
        trial     = '0;
        diff      = '0;
        prod      = '0;
        quo       = '0;
        rem       = '0;

        unique case (state_q)
            StIdle: begin
                if (mdu.start && !mdu.kill) begin
                    signed_a  = (mdu.funct3 == 3'b001) || (mdu.funct3 == 3'b010) ||
                                (mdu.funct3 == 3'b100) || (mdu.funct3 == 3'b110);
                    signed_b  = (mdu.funct3 == 3'b001) || (mdu.funct3 == 3'b100) ||
                                (mdu.funct3 == 3'b110);
                    neg_a_d   = signed_a && mdu.op_a[XLEN-1];
                    neg_b_d   = signed_b && mdu.op_b[XLEN-1];
                    a_mag     = neg_a_d ? -mdu.op_a : mdu.op_a;
                    b_mag_d   = neg_b_d ? -mdu.op_b : mdu.op_b;
                    div0      = mdu.funct3[2] && (mdu.op_b == '0);
                    ovf       = mdu.funct3[2] && !mdu.funct3[0] && (mdu.op_a == MinVal) &&
                                (mdu.op_b == '1);
                    funct3_d  = mdu.funct3;
                    cnt_d     = '0;
                    special_d = div0 || ovf;
                    // Special results are preloaded in quotient/remainder position.
                    if (div0) begin
                        acc_d = {mdu.op_a, {XLEN{1'b1}}};
                    end else if (ovf) begin
                        acc_d = {{XLEN{1'b0}}, mdu.op_a};
                    end else begin
                        acc_d = {{XLEN{1'b0}}, a_mag};
                    end
                    state_d = (div0 || ovf) ? StFix : StCalc;
                end
            end
            StCalc: begin
                if (!funct3_q[2]) begin
                    sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, b_mag_q};
                    if (acc_q[0]) begin
                        acc_d = {sum, acc_q[XLEN-1:1]};
                    end else begin
                        acc_d = {1'b0, acc_q[2*XLEN-1:1]};
                    end
                end else begin
                    trial = acc_q[2*XLEN-1:XLEN-1];
                    if (trial >= {1'b0, b_mag_q}) begin
                        diff  = trial[XLEN-1:0] - b_mag_q;
                        acc_d = {diff, acc_q[XLEN-2:0], 1'b1};
                    end else begin
                        acc_d = {trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
                    end
                end
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == CntW'(XLEN - 1)) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                prod = acc_q;
                quo  = acc_q[XLEN-1:0];
                rem  = acc_q[2*XLEN-1:XLEN];
                if (!special_q) begin
                    if (neg_a_q ^ neg_b_q) begin
                        prod = -acc_q;
                        quo  = -acc_q[XLEN-1:0];
                    end
                    if (neg_a_q) begin
                        rem = -acc_q[2*XLEN-1:XLEN];
                    end
                end
                case (funct3_q)
                    3'b000:                 result_d = prod[XLEN-1:0];
                    3'b001, 3'b010, 3'b011: result_d = prod[2*XLEN-1:XLEN];
                    3'b100, 3'b101:         result_d = quo;
                    default:                result_d = rem;
                endcase
                done_d  = 1'b1;
                state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Flush abandons any operation in flight without touching the published result.
        if (mdu.kill && (state_q != StIdle)) begin
            state_d  = StIdle;
            done_d   = 1'b0;
            result_d = result_q;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            funct3_q  <= '0;
            neg_a_q   <= 1'b0;
            neg_b_q   <= 1'b0;
            b_mag_q   <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            special_q <= 1'b0;
            result_q  <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            funct3_q  <= funct3_d;
            neg_a_q   <= neg_a_d;
            neg_b_q   <= neg_b_d;
            b_mag_q   <= b_mag_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            special_q <= special_d;
            result_q  <= result_d;
            done_q    <= done_d;
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vectors, handshake corner sequences and
// randomized operations against an arithmetic reference model.
module tb_muldiv_unit;
    localparam int unsigned XLEN = 32;
    localparam int NormLat = XLEN + 1;

    typedef struct {
        string       name;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;
    vec_t vecs[16];

    muldiv_unit_if #(.XLEN(XLEN)) mdu_if ();

    muldiv_unit #(.XLEN(XLEN)) u_dut (
        .clk (clk),
        .rst (rst),
        .mdu (mdu_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // RISC-V M semantics computed with wide arithmetic.
    function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [63:0] sa, sb, ua, ub, p;
        logic signed [31:0] q;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (f3)
            3'b000: begin p = ua * ub; return p[31:0]; end
            3'b001: begin p = sa * sb; return p[63:32]; end
            3'b010: begin p = sa * ub; return p[63:32]; end
            3'b011: begin p = ua * ub; return p[63:32]; end
            3'b100: begin
                if (b == 32'h0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                q = $signed(a) / $signed(b);
                return q;
            end
            3'b101: return (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
            3'b110: begin
                if (b == 32'h0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                q = $signed(a) % $signed(b);
                return q;
            end
            default: return (b == 32'h0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a,
                                   input logic [31:0] b);
        if (f3[2] && (b == 32'h0)) return 1;
        if (f3[2] && !f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return NormLat;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 6))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Count edges after the accept edge until done is seen (bounded).
    task automatic wait_done(output int lat);
        lat = 0;
        while (!mdu_if.done && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run_check(input string name, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int lat;
        @(negedge clk);
        mdu_if.start  = 1'b1;
        mdu_if.funct3 = f3;
        mdu_if.op_a   = a;
        mdu_if.op_b   = b;
        @(posedge clk);
        #1;
        // Operands only need to hold in the accept cycle.
        mdu_if.start  = 1'b0;
        mdu_if.funct3 = 3'($urandom);
        mdu_if.op_a   = $urandom;
        mdu_if.op_b   = $urandom;
        check({name, "_busy"}, 32'(mdu_if.busy), 32'd1);
        wait_done(lat);
        check({name, "_result"}, mdu_if.result, exp);
        check({name, "_latency"}, 32'(lat), 32'(exp_lat));
        @(posedge clk);
        #1;
        check({name, "_done_pulse"}, {30'b0, mdu_if.done, mdu_if.busy}, 32'd0);
    endtask

    initial begin
        int          lat;
        bit          seen;
        logic [2:0]  f3;
        logic [31:0] a, b;

        n_checks = 0;
        n_pass   = 0;
        rst           = 1'b1;
        mdu_if.start  = 1'b0;
        mdu_if.kill   = 1'b0;
        mdu_if.funct3 = 3'b000;
        mdu_if.op_a   = '0;
        mdu_if.op_b   = '0;

        vecs[0]  = '{"mulh_neg",    3'b001, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, NormLat};
        vecs[1]  = '{"mul_neg",     3'b000, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFA, NormLat};
        vecs[2]  = '{"mulhu_max",   3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, NormLat};
        vecs[3]  = '{"mulhsu",      3'b010, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, NormLat};
        vecs[4]  = '{"div_neg",     3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, NormLat};
        vecs[5]  = '{"rem_neg",     3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, NormLat};
        vecs[6]  = '{"divu",        3'b101, 32'd100,       32'd7,         32'd14,        NormLat};
        vecs[7]  = '{"remu",        3'b111, 32'd100,       32'd7,         32'd2,         NormLat};
        vecs[8]  = '{"divu_zero",   3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, 1};
        vecs[9]  = '{"remu_zero",   3'b111, 32'd5,         32'd0,         32'd5,         1};
        vecs[10] = '{"div_ovf",     3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
        vecs[11] = '{"rem_ovf",     3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1};
        vecs[12] = '{"div_zero",    3'b100, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF, 1};
        vecs[13] = '{"mulh_minmin", 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, NormLat};
        vecs[14] = '{"mul_zero",    3'b000, 32'd0,         32'h1234_5678, 32'd0,         NormLat};
        vecs[15] = '{"rem_negdiv",  3'b110, 32'd7,         32'hFFFF_FFFE, 32'd1,         NormLat};

        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {mdu_if.result[29:0], mdu_if.done, mdu_if.busy}, 32'd0);
        check("reset_result", mdu_if.result, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            run_check(vecs[i].name, vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);
        end

        // Second start during CALC must not disturb the MUL in flight.
        @(negedge clk);
        mdu_if.start = 1'b1; mdu_if.funct3 = 3'b000; mdu_if.op_a = 32'd6; mdu_if.op_b = 32'd7;
        @(posedge clk);
        #1;
        mdu_if.start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        mdu_if.start = 1'b1; mdu_if.funct3 = 3'b101; mdu_if.op_a = 32'd9;
        @(posedge clk);
        #1;
        mdu_if.start = 1'b0;
        wait_done(lat);
        check("start_ignored_result", mdu_if.result, 32'd42);
        check("start_ignored_latency", 32'(lat + 5), 32'(NormLat));
        @(posedge clk);
        #1;

        // Kill during a DIV: back to idle, no done, result retained.
        @(negedge clk);
        mdu_if.start = 1'b1; mdu_if.funct3 = 3'b100; mdu_if.op_a = 32'd100; mdu_if.op_b = 32'd7;
        @(posedge clk);
        #1;
        mdu_if.start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        mdu_if.kill = 1'b1;
        @(posedge clk);
        #1;
        mdu_if.kill = 1'b0;
        check("kill_busy", 32'(mdu_if.busy), 32'd0);
        check("kill_done", 32'(mdu_if.done), 32'd0);
        check("kill_result", mdu_if.result, 32'd42);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (mdu_if.done) seen = 1'b1;
        end
        check("kill_no_late_done", 32'(seen), 32'd0);

        // Kill together with start in idle: nothing accepted.
        @(negedge clk);
        mdu_if.start = 1'b1; mdu_if.kill = 1'b1; mdu_if.funct3 = 3'b000;
        @(posedge clk);
        #1;
        mdu_if.start = 1'b0; mdu_if.kill = 1'b0;
        check("kill_start_idle_busy", 32'(mdu_if.busy), 32'd0);

        // Asynchronous reset mid-CALC.
        @(negedge clk);
        mdu_if.start = 1'b1; mdu_if.funct3 = 3'b011; mdu_if.op_a = $urandom; mdu_if.op_b = 32'd5;
        @(posedge clk);
        #1;
        mdu_if.start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_outputs", {30'b0, mdu_if.done, mdu_if.busy}, 32'd0);
        check("async_rst_result", mdu_if.result, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_check("post_rst_mul", 3'b000, 32'd3, 32'd4, 32'd12, NormLat);

        // Randomized operations against the reference model.
        for (int i = 0; i < 120; i++) begin
            f3 = 3'($urandom);
            a  = pick_operand();
            b  = pick_operand();
            run_check("rand", f3, a, b, ref_model(f3, a, b), ref_lat(f3, a, b));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
